frame_pipeline_ctrl: RTL and testbench
======================================

// Module: frame_pipeline_ctrl
// PURPOSE
//  Sequencer for the camera -> frameBuffer -> frameBuffer_sorbel pipeline. Runs
//  one frame per start: FILL (buffer written from camera coords), SCAN (raster
//  read drives 3x3 window into Sobel buffer), DRAIN (wait for Sobel completion).
//  Owns readWrite and coordinate_X/Y of both buffers; replaces ad-hoc sequencing in top.
// PARAMETERS
//  WIDTH           768    image width; column index coord_y runs 0..WIDTH-1
//  HEIGHT          512    image height; row index coord_x runs 0..HEIGHT-1
//  COORD_W         11     width of all coordinate ports
//  TIMEOUT_CYCLES  4096   max DRAIN cycles waiting for sobel_done before error
//  FCNT_W          16     width of frame counter
// PORTS
//  CAMERA_CLK   in   1        sole clock, rising edge
//  rst_n        in   1        async active-low reset
//  start        in   1        request one frame; sampled only in IDLE
//  cam_x        in   COORD_W  camera row coordinate (from fileRead X)
//  cam_y        in   COORD_W  camera column coordinate (from fileRead Y)
//  fill_done    in   1        frameBuffer writeDone
//  sobel_done   in   1        frameBuffer_sorbel writeDone
//  buf_rw       out  1        1 = write/fill, 0 = read/scan; to both readWrite
//  coord_x      out  COORD_W  row coordinate to both buffers
//  coord_y      out  COORD_W  column coordinate to both buffers
//  busy         out  1        high in FILL, SCAN, DRAIN
//  frame_done   out  1        1-cycle pulse at end of each frame
//  timeout_err  out  1        sticky; set on DRAIN timeout, cleared by next accepted start
//  frame_count  out  FCNT_W   completed frames, wraps at 2^FCNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; buf_rw=0, coord_x=coord_y=0, busy=0,
//   frame_done=0, timeout_err=0, frame_count=0, timeout counter=0. Release sync'd by user.
//  All outputs registered. States IDLE, FILL, SCAN, DRAIN, DONE.
//  IDLE: coords held 0, buf_rw=0. start=1 -> FILL next cycle; clears timeout_err.
//  FILL: buf_rw=1; coord_x/coord_y <= cam_x/cam_y each cycle (1-cycle latency).
//   fill_done=1 -> SCAN; on that edge buf_rw<=0, coord_x<=0, coord_y<=0.
//  SCAN: raster, coord_y increments each cycle; at coord_y==WIDTH-1 -> coord_y<=0,
//   coord_x+1. At (HEIGHT-1, WIDTH-1) -> DRAIN, coords hold. Exactly
//   WIDTH*HEIGHT cycles in SCAN, first address (0,0), last (HEIGHT-1,WIDTH-1).
//  DRAIN: coords hold, buf_rw=0; timeout counter increments per cycle.
//   sobel_done=1 -> DONE. Counter reaches TIMEOUT_CYCLES-1 without sobel_done ->
//   timeout_err<=1, -> DONE. sobel_done on same cycle as timeout: no error.
//  DONE: one cycle; frame_done=1, frame_count+1, timeout counter cleared -> IDLE.
//  fill_done/sobel_done ignored outside FILL/DRAIN respectively.
//  start ignored while busy or in DONE (no queuing).
//  sobel_done asserted early (during SCAN) is ignored; only DRAIN samples it.
//  Reset mid-frame: immediate return to IDLE state values; frame_count cleared.
// CONFIGURATION
//  FRAME_LOOP_EN defined: DONE -> FILL directly (continuous video); start only
//   needed for first frame; busy stays 1 between frames; frame_done still pulses.
//  FRAME_LOOP_EN undefined: DONE -> IDLE; each frame requires new start pulse.
// TESTING (bench with WIDTH=4, HEIGHT=3, TIMEOUT_CYCLES=8)
//  Reset asserted mid-SCAN -> all outputs at reset values same cycle (async).
//  start, cam coords (0,0)..(2,3), fill_done at (2,3) -> buf_rw falls, SCAN
//   emits 12 addrs (0,0),(0,1)..(2,3), then DRAIN.
//  sobel_done 3 cycles into DRAIN -> DONE 1 cycle, frame_done pulse, frame_count=1,
//   timeout_err=0, IDLE with coords 0.
//  sobel_done never asserted -> DONE after 8 DRAIN cycles, timeout_err=1; stays 1
//   until next start accepted.
//  start pulsed in SCAN and DONE -> ignored; fill_done pulsed in SCAN -> no effect;
//   frame_count increments once.
//  FRAME_LOOP_EN: one start, 3 frames -> 3 frame_done pulses, frame_count=3,
//   busy never deasserts, FILL re-entered the cycle after each DONE.

Source files
------------

// File: rtl/frame_pipeline_ctrl.sv
// Frame sequencer for camera -> frameBuffer -> Sobel buffer: FILL, raster SCAN, DRAIN.
// Define FRAME_LOOP_EN for continuous video (DONE re-enters FILL without a new start).
module frame_pipeline_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int COORD_W        = 11,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FCNT_W         = 16
) (
  input  logic               CAMERA_CLK,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] cam_x,
  input  logic [COORD_W-1:0] cam_y,
  input  logic               fill_done,
  input  logic               sobel_done,
  output logic               buf_rw,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic [FCNT_W-1:0]  frame_count
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(WIDTH - 1);
  localparam int                 TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FILL, SCAN, DRAIN, DONE} ctrlState;

  ctrlState        state;
  logic [TO_W-1:0] timeoutCnt;

  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_rw      <= 1'b0;
      coord_x     <= '0;
      coord_y     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
      timeoutCnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          buf_rw  <= 1'b0;
          coord_x <= '0;
          coord_y <= '0;
          busy    <= 1'b0;
          if (start) begin
            state       <= FILL;
            buf_rw      <= 1'b1;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        FILL: begin
          if (fill_done) begin
            state   <= SCAN;
            buf_rw  <= 1'b0;
            coord_x <= '0;
            coord_y <= '0;
          end else begin
            coord_x <= cam_x;
            coord_y <= cam_y;
          end
        end
        SCAN: begin
          // Last raster address holds on the outputs through DRAIN and DONE.
          if (coord_y == LAST_Y) begin
            if (coord_x == LAST_X) begin
              state <= DRAIN;
            end else begin
              coord_y <= '0;
              coord_x <= coord_x + 1'b1;
            end
          end else begin
            coord_y <= coord_y + 1'b1;
          end
        end
        DRAIN: begin
          // sobel_done wins over a timeout landing on the same cycle.
          if (sobel_done || timeoutCnt == TO_LAST) begin
            state       <= DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            if (!sobel_done) begin
              timeout_err <= 1'b1;
            end
`ifdef FRAME_LOOP_EN
            busy <= 1'b1;
`else
            busy <= 1'b0;
`endif
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        DONE: begin
          timeoutCnt <= '0;
          coord_x    <= '0;
          coord_y    <= '0;
`ifdef FRAME_LOOP_EN
          state  <= FILL;
          buf_rw <= 1'b1;
          busy   <= 1'b1;
`else
          state  <= IDLE;
          buf_rw <= 1'b0;
          busy   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pipeline_ctrl.sv
// Bench for frame_pipeline_ctrl: phase/index reference model checked every cycle plus literal pins.
module tb_frame_pipeline_ctrl;
  localparam int W = 4, H = 3, T = 8, CW = 11, FW = 16;
  localparam int P_IDLE = 0, P_FILL = 1, P_SCAN = 2, P_DRAIN = 3, P_DONE = 4;
`ifdef FRAME_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, fill_done = 1'b0, sobel_done = 1'b0;
  logic [CW-1:0] cam_x = '0, cam_y = '0;
  logic          buf_rw, busy, frame_done, timeout_err;
  logic [CW-1:0] coord_x, coord_y;
  logic [FW-1:0] frame_count;

  int nCmp = 0, nMis = 0;
  int nDone = 0, nScan = 0, nDrain = 0, busyDrop = 0;
  bit cmpEn = 1'b0, busyWatch = 1'b0;

  always #5 clk = ~clk;

  frame_pipeline_ctrl #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .TIMEOUT_CYCLES(T), .FCNT_W(FW)
  ) dut (
    .CAMERA_CLK(clk), .rst_n(rst_n), .start(start), .cam_x(cam_x), .cam_y(cam_y),
    .fill_done(fill_done), .sobel_done(sobel_done), .buf_rw(buf_rw),
    .coord_x(coord_x), .coord_y(coord_y), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  // Reference model: frame phase, linear scan index, drain age, sticky error, frame tally.
  int            mPhase = P_IDLE, mK = 0, mD = 0;
  logic [CW-1:0] mFx = '0, mFy = '0;
  logic          mErr = 1'b0;
  logic [FW-1:0] mCnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase <= P_IDLE; mK <= 0; mD <= 0; mFx <= '0; mFy <= '0; mErr <= 1'b0; mCnt <= '0;
    end else begin
      case (mPhase)
        P_IDLE:  if (start) begin mPhase <= P_FILL; mErr <= 1'b0; mFx <= '0; mFy <= '0; end
        P_FILL:  if (fill_done) begin mPhase <= P_SCAN; mK <= 0; end
                 else begin mFx <= cam_x; mFy <= cam_y; end
        P_SCAN:  if (mK == W * H - 1) begin mPhase <= P_DRAIN; mD <= 0; end
                 else mK <= mK + 1;
        P_DRAIN: if (sobel_done || mD == T - 1) begin
                   mPhase <= P_DONE;
                   mCnt   <= mCnt + 1'b1;
                   if (!sobel_done) mErr <= 1'b1;
                 end else mD <= mD + 1;
        default: begin mPhase <= LOOP ? P_FILL : P_IDLE; mFx <= '0; mFy <= '0; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, 1 time unit after the active edge.
  initial begin
    logic [CW-1:0] ex, ey;
    forever begin
      @(posedge clk);
      #1;
      if (cmpEn) begin
        case (mPhase)
          P_FILL:  begin ex = mFx; ey = mFy; end
          P_SCAN:  begin ex = CW'(mK / W); ey = CW'(mK % W); end
          P_DRAIN, P_DONE: begin ex = CW'(H - 1); ey = CW'(W - 1); end
          default: begin ex = '0; ey = '0; end
        endcase
        chk("cyc_buf_rw", buf_rw, mPhase == P_FILL);
        chk("cyc_coord_x", coord_x, ex);
        chk("cyc_coord_y", coord_y, ey);
        chk("cyc_busy", busy, (mPhase == P_FILL || mPhase == P_SCAN || mPhase == P_DRAIN)
                              || (LOOP && mPhase == P_DONE));
        chk("cyc_frame_done", frame_done, mPhase == P_DONE);
        chk("cyc_timeout_err", timeout_err, mErr);
        chk("cyc_frame_count", frame_count, mCnt);
        if (mPhase == P_SCAN) nScan++;
        if (mPhase == P_DRAIN) nDrain++;
        if (busyWatch && busy !== 1'b1) busyDrop++;
        if (frame_done === 1'b1) begin
          nDone++;
          $display("frame end: frame_count=%0d timeout_err=%0b", frame_count, timeout_err);
        end
      end
    end
  end

  task automatic waitPhase(input int p, input int budget, input string name);
    int n = 0;
    while (mPhase != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mPhase != p) begin
      nCmp++;
      nMis++;
      $display("FAIL %s: phase %0d after %0d cycles, expected %0d", name, mPhase, n, p);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Camera raster (0,0)..(H-1,W-1), fill_done alongside the final coordinate.
  task automatic doFill();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cam_x = CW'(r);
        cam_y = CW'(c);
        fill_done = (r == H - 1 && c == W - 1);
        @(negedge clk);
      end
    end
    fill_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmpEn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_buf_rw", buf_rw, 0);
    chk("rst_coord_x", coord_x, 0);
    chk("rst_coord_y", coord_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FRAME_LOOP_EN
    pulseStart();
    waitPhase(P_FILL, 4, "loop_fill");
    busyWatch = 1'b1;
    for (int f = 0; f < 3; f++) begin
      doFill();
      waitPhase(P_DRAIN, 40, "loop_drain");
      @(negedge clk); sobel_done = 1'b1;
      @(negedge clk); sobel_done = 1'b0;
      chk("loop_done_pulse", frame_done, 1);
      @(negedge clk);
      chk("loop_refill_rw", buf_rw, 1);
    end
    busyWatch = 1'b0;
    chk("loop_frame_count", frame_count, 3);
    chk("loop_done_pulses", nDone, 3);
    chk("loop_busy_drops", busyDrop, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("loop_rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`else
    // Frame 1: stray start/fill_done/sobel_done during SCAN, start during DONE.
    nScan = 0;
    pulseStart();
    waitPhase(P_FILL, 4, "f1_fill");
    chk("f1_fill_rw", buf_rw, 1);
    doFill();
    chk("f1_scan_rw", buf_rw, 0);
    chk("f1_scan_first", {coord_x, coord_y}, 0);
    start = 1'b1; fill_done = 1'b1; sobel_done = 1'b1;
    @(negedge clk);
    start = 1'b0; fill_done = 1'b0; sobel_done = 1'b0;
    waitPhase(P_DRAIN, 40, "f1_drain");
    chk("f1_scan_cycles", nScan, 12);
    chk("f1_scan_last_x", coord_x, 2);
    chk("f1_scan_last_y", coord_y, 3);
    repeat (2) @(negedge clk);
    sobel_done = 1'b1;
    @(negedge clk);
    sobel_done = 1'b0;
    chk("f1_done_pulse", frame_done, 1);
    chk("f1_frame_count", frame_count, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_coords", {coord_x, coord_y}, 0);
    chk("f1_idle_err", timeout_err, 0);
    repeat (3) @(negedge clk);
    chk("f1_still_idle", busy, 0);
    chk("f1_done_pulses", nDone, 1);

    // Frame 2: no sobel_done, timeout after T DRAIN cycles, sticky error.
    nDrain = 0;
    pulseStart();
    waitPhase(P_FILL, 4, "f2_fill");
    doFill();
    waitPhase(P_DONE, 60, "f2_done");
    chk("f2_drain_cycles", nDrain, 8);
    chk("f2_timeout_err", timeout_err, 1);
    chk("f2_frame_count", frame_count, 2);
    repeat (5) @(negedge clk);
    chk("f2_err_sticky", timeout_err, 1);

    // Frame 3: accepted start clears the error; sobel_done on the last DRAIN cycle wins.
    pulseStart();
    waitPhase(P_FILL, 4, "f3_fill");
    chk("f3_err_cleared", timeout_err, 0);
    doFill();
    waitPhase(P_DRAIN, 40, "f3_drain");
    repeat (7) @(negedge clk);
    sobel_done = 1'b1;
    @(negedge clk);
    sobel_done = 1'b0;
    chk("f3_done_pulse", frame_done, 1);
    chk("f3_no_err", timeout_err, 0);
    chk("f3_frame_count", frame_count, 3);

    // Frame 4: asynchronous reset mid-SCAN.
    repeat (2) @(negedge clk);
    pulseStart();
    waitPhase(P_FILL, 4, "f4_fill");
    doFill();
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_coords", {coord_x, coord_y}, 0);
    chk("arst_buf_rw", buf_rw, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
`endif

    cmpEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end
endmodule
